// File: rtl/dot_acc_int32.sv
// dot_acc_int32: packet dot-product accumulator behind the integer multiplier.
// Sums products modulo 2^WIDTH until a term flagged last arrives.
// It then presents the sum, a saturating term count and a sticky signed-overflow
// flag on a registered valid/ready output.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_ACC  | collecting terms, in_ready=1, out_valid=0
// ST_HOLD | completed packet presented, in_ready=0, out_valid=1
module dot_acc_int32 #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_prod,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_sum,
   output logic [CNT_WIDTH-1:0] out_count,
   output logic                 out_ovf
);

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t               state_q;
   logic [WIDTH-1:0]     acc_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 ovf_q;
   logic [WIDTH-1:0]     sum_q;
   logic [CNT_WIDTH-1:0] count_q;
   logic                 res_ovf_q;

   logic [WIDTH-1:0]     acc_d;
   logic [CNT_WIDTH-1:0] cnt_d;
   logic                 ovf_d;
   logic                 in_xfer;

   // The output handshake is a function of the state register only.
   assign out_valid = (state_q == ST_HOLD);
   assign in_ready  = ~out_valid;
   assign in_xfer   = in_valid & in_ready;

   assign out_sum   = sum_q;
   assign out_count = count_q;
   assign out_ovf   = res_ovf_q;

   // Running values including the term currently offered.
   always_comb begin
      acc_d = acc_q + in_prod;
      cnt_d = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + 1'b1;
      ovf_d = ovf_q;
      if ((acc_q[WIDTH-1] == in_prod[WIDTH-1]) && (acc_d[WIDTH-1] != acc_q[WIDTH-1])) begin
         ovf_d = 1'b1;
      end
   end

   // Accumulate terms, latch the result on last, release on the output transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_ACC;
         acc_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         sum_q     <= '0;
         count_q   <= '0;
         res_ovf_q <= 1'b0;
      end else begin
         case (state_q)
            ST_ACC: begin
               if (in_xfer) begin
                  if (in_last) begin
                     sum_q     <= acc_d;
                     count_q   <= cnt_d;
                     res_ovf_q <= ovf_d;
                     acc_q     <= '0;
                     cnt_q     <= '0;
                     ovf_q     <= 1'b0;
                     state_q   <= ST_HOLD;
                  end else begin
                     acc_q <= acc_d;
                     cnt_q <= cnt_d;
                     ovf_q <= ovf_d;
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state_q <= ST_ACC;
               end
            end
            default: state_q <= ST_ACC;
         endcase
      end
   end

endmodule

// File: doc/dot_acc_int32.md
# dot_acc_int32

Sequential dot-product accumulator that sits directly downstream of the 32-bit integer multiplier. It accepts one product per cycle over a valid/ready handshake, sums a packet of products terminated by a `last` flag, and presents the wrap-around sum, term count and a sticky signed-overflow flag on a registered output handshake. Products are the lower WIDTH bits of each multiply, so all arithmetic is modulo 2^WIDTH.

## Interface
- `WIDTH`, default 32: product and sum width in bits.
- `CNT_WIDTH`, default 16: term-counter width in bits.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_prod` and `in_last` are valid.
- `in_ready` output 1: the block can accept a product this cycle.
- `in_prod` input WIDTH: product term, two's complement.
- `in_last` input 1: this term closes the current packet.
- `out_valid` output 1: the result registers hold a completed packet.
- `out_ready` input 1: the consumer accepts the result.
- `out_sum` output WIDTH: packet sum modulo 2^WIDTH.
- `out_count` output CNT_WIDTH: number of terms in the packet, saturating.
- `out_ovf` output 1: at least one signed overflow occurred during the packet.

## Operation
- There are two states.
  - ACC: collecting terms; `in_ready`=1 and `out_valid`=0.
  - HOLD: a result is presented; `in_ready`=0 and `out_valid`=1.
- An input transfer happens when `in_valid` && `in_ready`.
- Update on each input transfer in ACC:
  - `acc` <= `acc` + `in_prod`, truncated to WIDTH.
  - `cnt` <= `cnt`+1, saturating at 2^CNT_WIDTH−1.
  - `ovf` <= `ovf` | signed overflow. Signed overflow means both operand MSBs are equal and the sum MSB differs from them.
- Transfer with `in_last`=1:
  - Load `out_sum`/`out_count`/`out_ovf` with the updated values, which include the last term.
  - Clear `acc`, `cnt` and `ovf` to 0.
  - Go to HOLD.
- A single-term packet (first term has `in_last`=1) is legal: `out_count`=1 and `out_sum`=`in_prod`.
- An output transfer happens when `out_valid` && `out_ready`; the block then goes to ACC on the next edge.
- `out_sum`, `out_count` and `out_ovf` stay stable while `out_valid`=1 and are not cleared after the output transfer. They are don't-care when `out_valid`=0.
- `in_valid`=0 cycles inside a packet are bubbles: no state change.
- `in_prod` and `in_last` are ignored when no transfer occurs.
- `in_ready` is a combinational function of state only (`in_ready` = !`out_valid`). It never depends on `in_valid`.

## Timing
- Reset values: state ACC, `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_count`=0, `out_ovf`=0, and internal `acc`/`cnt`/`ovf`=0.
- Reset asserted mid-packet or during HOLD discards everything immediately (asynchronous). The first transfer after reset deassertion starts a new packet.
- Throughput: one term per cycle inside a packet.
- Latency: a last term accepted at edge N gives `out_valid`=1 from the cycle after edge N.
- With `out_ready` held at 1, HOLD lasts exactly one cycle. The next packet's first term is therefore accepted at edge N+2, a one-cycle bubble per packet.
- `out_ready`=0 stalls indefinitely in HOLD. Upstream sees `in_ready`=0 for the whole stall and must hold its data.
- `out_ready` asserted while `out_valid`=0 has no effect.

## Test plan
- Basic packet: products 3, 5, 7 (last) on consecutive cycles with `out_ready`=1 → one cycle after the last transfer, `out_valid`=1, `out_sum`=15, `out_count`=3, `out_ovf`=0. `out_valid` drops the following cycle and `in_ready` returns to 1.
- Wrap and overflow: products 0x7FFFFFFF then 0x00000001 (last) → `out_sum`=0x80000000, `out_ovf`=1. Next packet 0xFFFFFFFF, 0x00000001 (last) → `out_sum`=0, `out_ovf`=0 (unsigned carry only, flag cleared per packet).
- Backpressure: packet −2, 10 (last) with `out_ready`=0 for 5 cycles → `out_sum`=8 and `out_count`=2 stable for all 5 cycles. `in_ready`=0 throughout, and `in_valid` offered meanwhile is not consumed. After `out_ready`=1 the held term is accepted as the first term of the next packet.
- Bubbles and single-term packet: 4, idle, idle, 6 (last) → `out_sum`=10, `out_count`=2. Then 9 (last) alone → `out_sum`=9, `out_count`=1.
- Count saturation (CNT_WIDTH=4): 20 terms of value 1 → `out_count`=15, `out_sum`=20.
- Reset mid-operation: assert `rst` after 2 of 4 terms (1, 2) without a clock edge → outputs read reset values immediately. A new packet 5 (last) → `out_sum`=5, `out_count`=1.
